pattern_sequencer: RTL
======================

# pattern_sequencer

Controller that drives the serial input of the lab shift-register/FSM pipeline from a programmed bit pattern instead of a push-button. It loads a pattern and length, then on each shift strobe presents the next bit for the shift register and the Moore/Mealy detectors to consume. It repeats the pattern a programmed number of times, or forever, and then reports completion. It sits between the debounced switches/keys and the shift register input, sharing the same shift strobe.

## Interface
- `w`, 8: maximum pattern length in bits; must be ≥ 2. `lw = $clog2(w)`.
- `repeat_w`, 4: width of the repeat count and pass counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `en` in 1: shift strobe, one-cycle pulse; the same strobe drives the shift register.
- `start` in 1: level, sampled every cycle; acted on only in IDLE.
- `abort` in 1: level, sampled every cycle; acted on in any state.
- `pattern` in w: bits to emit, LSB first.
- `len` in lw: pattern length minus 1, so 0..w-1 selects 1..w bits.
- `repeats` in repeat_w: number of passes; 0 means loop forever.
- `bit_out` out 1: current bit, to shift register `in`.
- `bit_valid` out 1: high while in RUN.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse at completion.
- `bit_index` out lw: index of the bit currently presented.
- `pass_count` out repeat_w: completed passes in the current run.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - On `start` with `abort` low: capture `pattern`, `len` and `repeats` into shadow registers, clear index and pass count, go to RUN.
  - `en` is ignored in IDLE.
- **RUN**
  - `bit_out = pattern_q[bit_index]`, driven combinationally from registers only.
  - On `en` with `bit_index != len_q`: increment the index.
  - On `en` with `bit_index == len_q`: set index to 0 and `pass_count` to `pass_count + 1`.
    - If `repeats_q != 0` and `pass_count + 1 == repeats_q`: go to DONE.
    - Otherwise stay in RUN.
- **DONE**: assert `done` for exactly one cycle, then go to IDLE.
- **abort**: in any state, go to IDLE on the next edge and do not assert `done`.
  - `abort` wins over a simultaneous `en` or `start`.
- `start` while busy is ignored.
- Changes on `pattern`, `len` or `repeats` during a run have no effect until the next start.
- Infinite mode (`repeats = 0`): `pass_count` wraps modulo 2^repeat_w and `done` is never asserted.
- After a pass completes, `pass_count` holds its final value through DONE and IDLE. It clears only on the next accepted start.
- In IDLE: `bit_out = 0`, `bit_valid = 0`. `bit_index` reads 0.

## Timing
- Reset (asynchronous, immediate) puts the block in IDLE with every output 0 and the shadow registers cleared.
- Reset is legal mid-run.
- Start latency: `start` sampled high at edge N puts the block in RUN after N. `bit_out` shows `pattern[0]` from that cycle on.
- The consumer samples `bit_out` on the same edge at which `en` is high. The index advances on that edge, so each bit is consumed exactly once.
- A run of `(len+1)·repeats` strobes ends as follows:
  - the final strobe edge enters DONE;
  - `done` is high for the following cycle;
  - `busy` drops one cycle later.
- Back-to-back runs: earliest new start is accepted at the edge after DONE, i.e. from IDLE.
- `en` in the same cycle as the accepted start is ignored. The first consumed bit is always index 0.

## Structure
- Package `pattern_sequencer_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t`;
  - no other shared constants.
- Single module with no sub-module. The index and pass counters are local registers, because their wrap/terminal logic differs from the generic free-running counter.

## Test plan
- **Single pass.** `pattern = 8'b1011_0010`, `len = 7`, `repeats = 1`, `en` every 4 cycles.
  - Required: `bit_out` sampled at strobes reads 0,1,0,0,1,1,0,1.
  - `done` pulses once, the cycle after the 8th strobe.
  - `busy` is low from the next cycle; `pass_count = 1`.
- **Repeats.** `pattern = 3'b110`, `len = 2`, `repeats = 3`.
  - Required: 9 strobes produce 0,1,1 three times.
  - `pass_count` steps 0→1→2→3; `done` pulses after the 9th strobe and never earlier.
- **Infinite mode and abort.** `len = 0`, `pattern[0] = 1`, `repeats = 0`, then 40 strobes.
  - Required: `bit_out` is constantly 1, `done` is never asserted, and `pass_count` wraps 15→0.
  - Assert `abort` together with `en`: block is IDLE the next cycle, `bit_out = 0`, no `done`.
- **Ignored inputs.** Pulse `start` mid-run and change `pattern` to all-zero mid-run.
  - Required: the sequence is unchanged, the run completes with the original bits, and no restart occurs.
- **Reset mid-run.** Assert `reset` asynchronously between clock edges at `bit_index = 5`.
  - Required: all outputs are 0 before the next edge.
  - After release with `start` low, the block stays IDLE.
- **Start/en collision.** `start` and `en` high in the same IDLE cycle.
  - Required: the first consumed bit on the next strobe is `pattern[0]` and `bit_index = 0` at that strobe.

Source files
------------

// File: rtl/pattern_sequencer_pkg.sv
// Shared types for the pattern sequencer.
// Holds the controller state encoding used by the sequencer FSM.
package pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: emits a programmed bit pattern LSB first, one bit
// per shift strobe, repeating it a set number of times or forever.
// Ports:
//   clk, reset      - clock, async active-high reset
//   en              - shift strobe shared with the shift register
//   start, abort    - run control levels (abort wins)
//   pattern, len    - bits to emit, length minus 1
//   repeats         - pass count, 0 = forever
//   bit_out         - current bit for the shift register input
//   bit_valid, busy - RUN / RUN-or-DONE status
//   done            - one-cycle completion pulse
//   bit_index       - index of the bit being presented
//   pass_count      - completed passes in the current run
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter  int w        = 8,
  parameter  int repeat_w = 4,
  localparam int lw       = $clog2(w)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                start,
  input  logic                abort,
  input  logic [w-1:0]        pattern,
  input  logic [lw-1:0]       len,
  input  logic [repeat_w-1:0] repeats,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                busy,
  output logic                done,
  output logic [lw-1:0]       bit_index,
  output logic [repeat_w-1:0] pass_count
);

  seq_state_t          state_q, state_d;
  logic [w-1:0]        pattern_q, pattern_d;
  logic [lw-1:0]       len_q, len_d;
  logic [repeat_w-1:0] repeats_q, repeats_d;
  logic [lw-1:0]       idx_q, idx_d;
  logic [repeat_w-1:0] pass_q, pass_d;
  logic [repeat_w-1:0] pass_inc;

  // Wraps naturally, which gives the modulo behaviour in infinite mode.
  assign pass_inc = pass_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      repeats_q <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      repeats_q <= repeats_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    repeats_d = repeats_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    if (abort) begin
      // Index clears so it reads 0 in IDLE; pass count is kept.
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pattern_d = pattern;
            len_d     = len;
            repeats_d = repeats;
            idx_d     = '0;
            pass_d    = '0;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (idx_q == len_q) begin
              idx_d  = '0;
              pass_d = pass_inc;
              if (repeats_q != '0 &&
                  pass_inc == repeats_q) begin
                state_d = DONE;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bit_valid  = (state_q == RUN);
  assign busy       = (state_q == RUN) ||
                      (state_q == DONE);
  assign done       = (state_q == DONE);
  assign bit_out    = bit_valid & pattern_q[idx_q];
  assign bit_index  = idx_q;
  assign pass_count = pass_q;

endmodule
